priority_encoder16_4_seq: RTL and testbench

- Registered 16-to-4 priority encoder with request latching and a valid/ack handshake.
- Functional inverse of the 4-to-16 decoder: it turns one-hot or multi-hot request lines back into a 4-bit index.
- Sits between peripheral/exception request lines and the MIPS control unit, which consumes one encoded request at a time and acknowledges it.

---
 rtl/priority_encoder16_4_seq.sv | 113 +++++++++++
 tb/tb_priority_encoder16_4_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/priority_encoder16_4_seq.sv
// priority_encoder16_4_seq
//
// Registered 16-to-4 priority encoder that sits between the peripheral and
// exception request lines and the control unit. Requests are latched into a
// pending register. The highest-index pending request is granted as a 4-bit
// code with a valid/ack handshake. The consumer takes one code at a time and
// acknowledges it, which clears that bit from the pending set.
//
// Ports:
//   clk      rising-edge clock, the only clock
//   rst      synchronous, active-high reset; overrides every other input
//   en       grant enable; requests are still latched while it is low
//   req      request lines, sampled every cycle (a 1-cycle pulse is enough)
//   ack      consumer accepts the current code; ignored while valid=0
//   code     encoded index of the granted request
//   valid    code holds a granted, unacknowledged request
//   pending  latched requests not yet acknowledged, including the granted one
//   any      OR-reduction of pending
//
// N_REQ must equal 2**CODE_W so that every request line has a code.

module priority_encoder16_4_seq #(
  parameter int N_REQ  = 16,
  parameter int CODE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_REQ-1:0]  req,
  input  logic              ack,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic [N_REQ-1:0]  pending,
  output logic              any
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [CODE_W-1:0]  code_next;
  logic [CODE_W-1:0]  top_index;
  logic [N_REQ-1:0]   pending_next;
  logic [N_REQ-1:0]   clr;

  // Find the highest set bit of the registered pending value. Later loop
  // iterations override earlier ones, so the top index wins. Selection never
  // looks at raw req, so a new request is granted one edge after it is latched.
  always_comb begin
    top_index = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pending[i]) begin
        top_index = CODE_W'(i);
      end
    end
  end

  // Clear mask for the granted bit on an accepted handshake. req is OR-ed in
  // after the clear, so a re-request of the granted line in the same cycle
  // keeps it pending and it is granted again later.
  always_comb begin
    clr = '0;
    if (state == BUSY && ack) begin
      clr = {{(N_REQ-1){1'b0}}, 1'b1} << code;
    end
    pending_next = (pending & ~clr) | req;
  end

  // Next-state logic. IDLE issues a grant only when enabled and something is
  // pending. BUSY freezes code until ack, so a higher-priority arrival does
  // not pre-empt the grant and en=0 does not withdraw it. Returning to IDLE
  // after ack creates the one-cycle bubble between grants.
  always_comb begin
    state_next = state;
    code_next  = code;
    unique case (state)
      IDLE: begin
        if (en && (pending != '0)) begin
          code_next  = top_index;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (ack) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, code and pending registers. Reset drops any grant in flight and
  // all latched requests; nothing is replayed afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      code    <= '0;
      pending <= '0;
    end else begin
      state   <= state_next;
      code    <= code_next;
      pending <= pending_next;
    end
  end

  assign valid = (state == BUSY);
  assign any   = |pending;

endmodule

// File: tb/tb_priority_encoder16_4_seq.sv
// tb_priority_encoder16_4_seq
//
// Self-checking bench for priority_encoder16_4_seq. A transaction-level
// reference model tracks the pending set, the grant and the valid flag. It
// picks the winner arithmetically as the position of the highest set bit.
// Directed steps cover the reset, grant, drain, pre-emption, enable and
// collision scenarios. A randomized phase follows them.

module tb_priority_encoder16_4_seq;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] req;
  logic        ack;
  logic [3:0]  code;
  logic        valid;
  logic [15:0] pending;
  logic        any;

  int checks;
  int failures;

  // Reference model state
  logic [15:0] m_pending;
  logic [3:0]  m_code;
  logic        m_valid;

  priority_encoder16_4_seq #(
    .N_REQ (16),
    .CODE_W(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .req    (req),
    .ack    (ack),
    .code   (code),
    .valid  (valid),
    .pending(pending),
    .any    (any)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Index of the highest set bit, computed as ceil(log2(v+1)) - 1
  function automatic logic [3:0] highest_bit(input logic [15:0] v);
    int unsigned n;
    n = $clog2(int'(v) + 1) - 1;
    return n[3:0];
  endfunction

  // Advance the model by one clock edge using the inputs seen at that edge
  task automatic model_edge();
    logic [15:0] cleared;
    if (rst) begin
      m_pending = '0;
      m_code    = '0;
      m_valid   = 1'b0;
    end else begin
      cleared = m_pending;
      if (m_valid && ack) begin
        cleared[m_code] = 1'b0;
      end
      if (!m_valid) begin
        if (en && m_pending != 16'h0) begin
          m_code  = highest_bit(m_pending);
          m_valid = 1'b1;
        end
      end else if (ack) begin
        m_valid = 1'b0;
      end
      m_pending = cleared | req;
    end
  endtask

  // Compare all outputs against the model
  task automatic checkOutput(input string tag);
    checks += 4;
    assert (code === m_code) else begin
      failures++;
      $error("[TB] FAIL %s code: observed=%0d expected=%0d", tag, code, m_code);
    end
    assert (valid === m_valid) else begin
      failures++;
      $error("[TB] FAIL %s valid: observed=%b expected=%b", tag, valid, m_valid);
    end
    assert (pending === m_pending) else begin
      failures++;
      $error("[TB] FAIL %s pending: observed=%h expected=%h", tag, pending, m_pending);
    end
    assert (any === (m_pending != 16'h0)) else begin
      failures++;
      $error("[TB] FAIL %s any: observed=%b expected=%b", tag, any, (m_pending != 16'h0));
    end
  endtask

  // Compare one observed value against a scenario constant
  task automatic checkConst(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model, then check #1 later
  task automatic applyStimulus(input logic r, input logic e, input logic [15:0] rq,
                               input logic a, input string tag);
    rst = r;
    en  = e;
    req = rq;
    ack = a;
    @(posedge clk);
    model_edge();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [3:0] drained [$];
    logic [3:0] drain_expect [4];
    logic [15:0] rq;

    checks    = 0;
    failures  = 0;
    m_pending = '0;
    m_code    = '0;
    m_valid   = 1'b0;
    rst = 1'b1;
    en  = 1'b0;
    req = '0;
    ack = 1'b0;

    // Reset overrides a full request vector and ack
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 1'b1, "reset0");
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 1'b1, "reset1");
    checkConst("reset_pending", 32'(pending), 32'h0);
    checkConst("reset_code", 32'(code), 32'h0);
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, "idle");

    // Single pulse on bit 5
    applyStimulus(1'b0, 1'b1, 16'h0020, 1'b0, "single_latch");
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, "single_grant");
    checkConst("single_code", 32'(code), 32'd5);
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1, "single_ack");
    checkConst("single_valid_after_ack", 32'(valid), 32'd0);

    // Multi-hot drain: ack whenever valid, record each grant
    applyStimulus(1'b0, 1'b1, 16'h8421, 1'b0, "drain_latch");
    for (int i = 0; i < 10; i++) begin
      if (m_valid) drained.push_back(code);
      applyStimulus(1'b0, 1'b1, 16'h0000, m_valid, "drain");
    end
    drain_expect = '{4'd15, 4'd10, 4'd5, 4'd0};
    checkConst("drain_count", 32'(drained.size()), 32'd4);
    for (int i = 0; i < 4 && i < drained.size(); i++) begin
      checkConst("drain_order", 32'(drained[i]), 32'(drain_expect[i]));
    end
    checkConst("drain_any", 32'(any), 32'd0);

    // No pre-emption: bit 14 arrives while code 3 is granted
    applyStimulus(1'b0, 1'b1, 16'h0008, 1'b0, "preempt_latch");
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, "preempt_grant3");
    applyStimulus(1'b0, 1'b1, 16'h4000, 1'b0, "preempt_hi_req");
    checkConst("preempt_hold", 32'(code), 32'd3);
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, "preempt_hold2");
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1, "preempt_ack");
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, "preempt_grant14");
    checkConst("preempt_code14", 32'(code), 32'd14);
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1, "preempt_ack14");

    // Enable gating
    applyStimulus(1'b0, 1'b0, 16'h0101, 1'b0, "en_latch");
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, "en_hold");
    checkConst("en_no_grant", 32'(valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, "en_grant8");
    checkConst("en_code8", 32'(code), 32'd8);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, "en_low_busy");
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1, "en_ack8");
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, "en_grant0");
    checkConst("en_code0", 32'(code), 32'd0);
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1, "en_ack0");

    // Ack/req collision on bit 7, then stray ack with valid low
    applyStimulus(1'b0, 1'b1, 16'h0080, 1'b0, "coll_latch");
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, "coll_grant7");
    applyStimulus(1'b0, 1'b1, 16'h0080, 1'b1, "coll_ack_req");
    checkConst("coll_pending", 32'(pending), 32'h0080);
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, "coll_regrant");
    checkConst("coll_code7", 32'(code), 32'd7);
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1, "coll_ack");
    applyStimulus(1'b0, 1'b0, 16'h0002, 1'b0, "stray_latch");
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, "stray_ack");
    checkConst("stray_pending", 32'(pending), 32'h0002);

    // Reset mid-handshake drops grant and pending bits
    applyStimulus(1'b0, 1'b1, 16'h1000, 1'b0, "midrst_grant");
    applyStimulus(1'b1, 1'b1, 16'h0000, 1'b0, "midrst_reset");
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, "midrst_after");
    checkConst("midrst_valid", 32'(valid), 32'd0);

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      rq = '0;
      if ($urandom_range(0, 2) == 0) rq = 16'(1) << $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) rq = 16'($urandom);
      applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                    rq, 1'($urandom_range(0, 1)), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
